uart_tx_arbiter: RTL

- Shares the single UART transmit line between NUM_REQ independent byte producers (button handlers, LED status reporters, echo path).
- Round-robin arbitration per byte; the winning byte is serialised as 8N1 at the baud rate set by CLK_DIV.
- Runs on the 100 MHz system clock with an internal baud-enable counter, not a derived clock.
- Sits between the requesters and the UART_TX pin in chip.

---
 rtl/uart_tx_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmit line between NUM_REQ byte producers.
// Optional build macro UART_ARB_LOCK_EN adds req_last and locks the line for multi-byte messages.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CLK_DIV = 868,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   req_last,
`endif
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_tx,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_r, state_nx_s;
  logic [CNT_W-1:0] baud_r, baud_nx_s;
  logic [2:0]       bit_r, bit_nx_s;
  logic [7:0]       shift_r, shift_nx_s;
  logic [ID_W-1:0]  ptr_r, ptr_nx_s;
  logic [ID_W-1:0]  gid_r, gid_nx_s;
  logic             busy_r, busy_nx_s;
  logic             tx_r, tx_nx_s;
`ifdef UART_ARB_LOCK_EN
  logic             lock_r, lock_nx_s;
  logic [ID_W-1:0]  lock_id_r, lock_id_nx_s;
`endif

  logic             tick_s;
  logic             win_found_s;
  logic [ID_W-1:0]  win_idx_s;
  logic [ID_W-1:0]  cand_s;
  logic [NUM_REQ-1:0] ready_s;
  logic             accept_s;
  logic [7:0]       win_byte_s;

  assign tick_s = (baud_r == CNT_LAST);

  // Round-robin search starting just after the last winner; a held lock overrides it.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = ID_W'((int'(ptr_r) + k) % NUM_REQ);
      if (!win_found_s && req_valid[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
`ifdef UART_ARB_LOCK_EN
    if (lock_r) begin
      win_found_s = req_valid[lock_id_r];
      win_idx_s   = lock_id_r;
    end else begin
      win_found_s = win_found_s;
    end
`endif
  end

  // Accept strobe is only offered in IDLE and never while reset is asserted.
  always_comb begin
    ready_s = '0;
    if ((state_r == IDLE) && !reset && win_found_s) begin
      ready_s[win_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign accept_s   = |(req_valid & ready_s);
  assign win_byte_s = req_data[{win_idx_s, 3'b000} +: 8];

  // Frame sequencer: next-state and next-register values.
  always_comb begin
    state_nx_s = state_r;
    baud_nx_s  = baud_r;
    bit_nx_s   = bit_r;
    shift_nx_s = shift_r;
    ptr_nx_s   = ptr_r;
    gid_nx_s   = gid_r;
    busy_nx_s  = busy_r;
    tx_nx_s    = tx_r;
`ifdef UART_ARB_LOCK_EN
    lock_nx_s    = lock_r;
    lock_id_nx_s = lock_id_r;
`endif
    case (state_r)
      IDLE: begin
        baud_nx_s = '0;
        if (accept_s) begin
          state_nx_s = START;
          shift_nx_s = win_byte_s;
          ptr_nx_s   = win_idx_s;
          gid_nx_s   = win_idx_s;
          busy_nx_s  = 1'b1;
          tx_nx_s    = 1'b0;
          bit_nx_s   = 3'd0;
`ifdef UART_ARB_LOCK_EN
          lock_nx_s    = ~req_last[win_idx_s];
          lock_id_nx_s = win_idx_s;
`endif
        end else begin
          tx_nx_s = 1'b1;
        end
      end
      START: begin
        if (tick_s) begin
          baud_nx_s  = '0;
          state_nx_s = DATA;
          tx_nx_s    = shift_r[0];
          shift_nx_s = {1'b0, shift_r[7:1]};
        end else begin
          baud_nx_s = baud_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (tick_s) begin
          baud_nx_s = '0;
          if (bit_r == 3'd7) begin
            state_nx_s = STOP;
            tx_nx_s    = 1'b1;
          end else begin
            tx_nx_s    = shift_r[0];
            shift_nx_s = {1'b0, shift_r[7:1]};
            bit_nx_s   = bit_r + 3'd1;
          end
        end else begin
          baud_nx_s = baud_r + CNT_W'(1);
        end
      end
      STOP: begin
        if (tick_s) begin
          baud_nx_s  = '0;
          state_nx_s = IDLE;
          busy_nx_s  = 1'b0;
        end else begin
          baud_nx_s = baud_r + CNT_W'(1);
        end
      end
      default: begin
        state_nx_s = IDLE;
        baud_nx_s  = '0;
        busy_nx_s  = 1'b0;
        tx_nx_s    = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      baud_r  <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      ptr_r   <= ID_W'(NUM_REQ - 1);
      gid_r   <= '0;
      busy_r  <= 1'b0;
      tx_r    <= 1'b1;
`ifdef UART_ARB_LOCK_EN
      lock_r    <= 1'b0;
      lock_id_r <= '0;
`endif
    end else begin
      state_r <= state_nx_s;
      baud_r  <= baud_nx_s;
      bit_r   <= bit_nx_s;
      shift_r <= shift_nx_s;
      ptr_r   <= ptr_nx_s;
      gid_r   <= gid_nx_s;
      busy_r  <= busy_nx_s;
      tx_r    <= tx_nx_s;
`ifdef UART_ARB_LOCK_EN
      lock_r    <= lock_nx_s;
      lock_id_r <= lock_id_nx_s;
`endif
    end
  end

  assign req_ready = ready_s;
  assign uart_tx   = tx_r;
  assign busy      = busy_r;
  assign grant_id  = gid_r;

endmodule
